// File: rtl/bcd2binary_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// digit geometry, FSM state encoding and a digit-validity helper.
package bcd2binary_seq_pkg;

   localparam int BCD_DIGIT_W   = 4;
   localparam int BCD_MAX_DIGIT = 9;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] digit);
      return digit > BCD_DIGIT_W'(BCD_MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational x10 multiply-accumulate step: o_acc = i_acc*10 + i_digit (mod 2**BW),
// plus a flag for a non-decimal digit.
module bcd_mac10
   import bcd2binary_seq_pkg::*;
#(
   parameter int BW = 8
) (
   input  logic [BW-1:0]          i_acc,
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [BW-1:0]          o_acc,
   output logic                   o_dig_err
);

   logic [BW-1:0] w_x8;
   logic [BW-1:0] w_x2;

   // x10 as x8 + x2 keeps this to shifts and one adder chain.
   assign w_x8      = i_acc << 3;
   assign w_x2      = i_acc << 1;
   assign o_acc     = w_x8 + w_x2 + BW'(i_digit);
   assign o_dig_err = digit_invalid(i_digit);

endmodule

// File: rtl/bcd2binary_seq.sv
// Multi-cycle BCD-to-binary converter: Horner's method, MSD first, one digit per clock
// through a single shared x10 MAC, with a start/busy/done handshake.
module bcd2binary_seq
   import bcd2binary_seq_pkg::*;
#(
   parameter int K  = 2,
   parameter int BW = 4 * K
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*K-1:0]       bcd,
   output logic                 busy,
   output logic                 done,
   output logic [BW-1:0]        bin,
   output logic                 err
);

   localparam int              CW       = $clog2(K + 1);
   localparam int              SW       = BCD_DIGIT_W * K;
   localparam logic [CW-1:0]   LAST_CNT = CW'(K - 1);

   state_t          r_state;
   state_t          w_state_next;
   logic            w_load;
   logic            w_step;
   logic            w_last;

   logic [SW-1:0]   r_shift;
   logic [BW-1:0]   r_acc;
   logic [CW-1:0]   r_cnt;
   logic            r_err_acc;
   logic [BW-1:0]   r_bin;
   logic            r_err;
   logic            r_done;

   logic [BW-1:0]   w_acc_next;
   logic            w_dig_err;
   logic            w_err_next;

   bcd_mac10 #(
      .BW (BW)
   ) u_mac (
      .i_acc     (r_acc),
      .i_digit   (r_shift[SW-1 -: BCD_DIGIT_W]),
      .o_acc     (w_acc_next),
      .o_dig_err (w_dig_err)
   );

   assign w_err_next = r_err_acc | w_dig_err;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      w_state_next = r_state;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_step = 1'b1;
            if (r_cnt == LAST_CNT) begin
               w_last       = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift   <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_err_acc <= 1'b0;
         r_bin     <= '0;
         r_err     <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_load) begin
            r_shift   <= bcd;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err_acc <= 1'b0;
         end else if (w_step) begin
            r_shift   <= r_shift << BCD_DIGIT_W;
            r_acc     <= w_acc_next;
            r_cnt     <= r_cnt + CW'(1);
            r_err_acc <= w_err_next;
         end
         // Results are published only on the final digit so bin/err stay stable in between.
         if (w_last) begin
            r_bin <= w_acc_next;
            r_err <= w_err_next;
         end
      end
   end

   assign busy = (r_state == ST_RUN);
   assign done = r_done;
   assign bin  = r_bin;
   assign err  = r_err;

endmodule

// File: tb/tb_bcd2binary_seq.sv
// Scoreboard bench for bcd2binary_seq at K=2 and K=4: a driver pushes expected results
// from a positional-weight reference model, an independent monitor pops on each done.
module tb_bcd2binary_seq;

   typedef struct {
      logic [15:0] bin;
      logic        err;
      int          accept;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst    [2];
   logic        start  [2];
   logic [15:0] bcd_in [2];
   logic        busy   [2];
   logic        done   [2];
   logic        err_o  [2];
   logic [7:0]  bin_k2;
   logic [15:0] bin_k4;
   logic [15:0] bin_o  [2];

   assign bin_o[0] = {8'h00, bin_k2};
   assign bin_o[1] = bin_k4;

   bcd2binary_seq #(.K(2)) u_dut_k2 (
      .clk   (clk),
      .rst   (rst[0]),
      .start (start[0]),
      .bcd   (bcd_in[0][7:0]),
      .busy  (busy[0]),
      .done  (done[0]),
      .bin   (bin_k2),
      .err   (err_o[0])
   );

   bcd2binary_seq #(.K(4)) u_dut_k4 (
      .clk   (clk),
      .rst   (rst[1]),
      .start (start[1]),
      .bcd   (bcd_in[1]),
      .busy  (busy[1]),
      .done  (done[1]),
      .bin   (bin_k4),
      .err   (err_o[1])
   );

   exp_t        sb [2][$];
   int          cycle = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          armed = 1'b0;
   logic [15:0] hold_bin [2];
   logic        hold_err [2];

   always @(posedge clk) cycle <= cycle + 1;

   function automatic int k_of(input int d);
      return (d == 0) ? 2 : 4;
   endfunction

   // Reference: value = sum(digit_i * 10**i) mod 2**(4K); err if any digit exceeds 9.
   function automatic exp_t model(input int k, input logic [15:0] v, input int accept);
      exp_t       r;
      longint     val = 0;
      longint     w   = 1;
      logic [3:0] dg;
      r.err = 1'b0;
      for (int i = 0; i < k; i++) begin
         dg  = v[4*i +: 4];
         val = val + longint'(dg) * w;
         w   = w * 10;
         if (dg > 4'd9) r.err = 1'b1;
      end
      val      = val % (longint'(1) << (4 * k));
      r.bin    = 16'(val);
      r.accept = accept;
      r.due    = accept + k;
      return r;
   endfunction

   task automatic check(input string name, input int d, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d cycle %0d: got %0h want %0h", name, d, cycle, act, exp);
      end
   endtask

   function automatic bit model_busy(input int d, input int c);
      return (sb[d].size() > 0) && (sb[d][0].accept <= c) && (sb[d][0].due > c);
   endfunction

   always @(negedge clk) begin
      if (armed) begin
         for (int d = 0; d < 2; d++) begin
            exp_t e;
            if (done[d] === 1'b1) begin
               if (sb[d].size() == 0) begin
                  check("unexpected_done", d, 32'd1, 32'd0);
               end else begin
                  e = sb[d].pop_front();
                  check("bin", d, 32'(bin_o[d]), 32'(e.bin));
                  check("err", d, 32'(err_o[d]), 32'(e.err));
                  check("latency", d, 32'(cycle), 32'(e.due));
                  hold_bin[d] = e.bin;
                  hold_err[d] = e.err;
               end
            end else begin
               check("done_low", d, 32'(done[d]), 32'd0);
               check("bin_hold", d, 32'(bin_o[d]), 32'(hold_bin[d]));
               check("err_hold", d, 32'(err_o[d]), 32'(hold_err[d]));
            end
            if (sb[d].size() > 0 && sb[d][0].due < cycle) begin
               check("missed_done", d, 32'(cycle), 32'(sb[d][0].due));
               void'(sb[d].pop_front());
            end
            check("busy", d, 32'(busy[d]), 32'(model_busy(d, cycle)));
            if (rst[d]) begin
               sb[d].delete();
               hold_bin[d] = '0;
               hold_err[d] = 1'b0;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; presents start for one cycle and predicts acceptance.
   task automatic issue(input int d, input logic [15:0] v);
      start[d]  = 1'b1;
      bcd_in[d] = v;
      if (!rst[d] && !model_busy(d, cycle))
         sb[d].push_back(model(k_of(d), v, cycle + 1));
      tick(1);
      start[d]  = 1'b0;
      bcd_in[d] = 16'($urandom);
   endtask

   task automatic pulse_reset(input int d);
      rst[d] = 1'b1;
      tick(1);
      rst[d] = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d]      = 1'b1;
         start[d]    = 1'b0;
         bcd_in[d]   = '0;
         hold_bin[d] = '0;
         hold_err[d] = 1'b0;
      end
      tick(1);
      armed = 1'b1;
      tick(1);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      tick(1);

      issue(0, 16'h0042); tick(3);
      issue(0, 16'h0099); tick(1);
      issue(0, 16'h0000); tick(3);
      issue(0, 16'h003A); tick(3);
      issue(0, 16'h0015); tick(3);
      issue(0, 16'h0012);
      issue(0, 16'h0055); tick(4);
      issue(0, 16'h0037);
      pulse_reset(0);
      issue(0, 16'h0068); tick(4);
      issue(1, 16'h9999); tick(6);
      issue(1, 16'h0001); tick(6);

      for (int n = 0; n < 300; n++) begin
         int d;
         d = int'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) begin
            pulse_reset(d);
         end else begin
            issue(d, 16'($urandom));
         end
         tick(int'($urandom_range(0, 3)));
      end

      tick(12);
      for (int d = 0; d < 2; d++)
         check("sb_drain", d, 32'(sb[d].size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
